pipe_shifter: RTL and testbench

PIPE_SHIFTER -- requirements
Module: pipe_shifter

---
 rtl/pipe_shifter_pkg.sv | 11 +
 rtl/pipe_shifter_shift_level.sv | 51 +++++
 rtl/pipe_shifter.sv | 144 ++++++++++++++
 tb/tb_pipe_shifter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_shifter_pkg.sv
// Shared shift-mode encodings used by the shifter, ALU and control decoders.
package pipe_shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_ROTR = 2'b11
  } shift_mode_e;

endpackage

// File: rtl/pipe_shifter_shift_level.sv
// Combinational slice of the log-shifter: levels FIRST_LEVEL .. FIRST_LEVEL+NUM_LEVELS-1.
// Also returns the residual shift amount with the consumed bits cleared.
module shift_level
  import pipe_shifter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FIRST_LEVEL = 0,
  parameter int NUM_LEVELS  = 1
) (
  input  logic [WIDTH-1:0]         data_i,
  input  logic [$clog2(WIDTH)-1:0] shamt_i,
  input  shift_mode_e              mode_i,
  input  logic                     sign_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(WIDTH)-1:0] shamt_o
);

  logic [WIDTH-1:0] lvl [NUM_LEVELS+1];
  logic             unused_ok;

  assign lvl[0]    = data_i;
  assign data_o    = lvl[NUM_LEVELS];
  assign unused_ok = ^{mode_i, sign_i};

  for (genvar j = 0; j < NUM_LEVELS; j++) begin : g_lvl
    localparam int AMT = 1 << (FIRST_LEVEL + j);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] shifted;

    assign x = lvl[j];

    // SRA fills from the operand's original MSB, not from the partially shifted value.
    always_comb begin
      shifted = x;
      case (mode_i)
        SH_SLL:  shifted = x << AMT;
        SH_SRL:  shifted = x >> AMT;
        SH_SRA:  shifted = (x >> AMT) | (sign_i ? ~({WIDTH{1'b1}} >> AMT) : '0);
        default: shifted = (x >> AMT) | (x << (WIDTH - AMT));
      endcase
    end

    assign lvl[j+1] = shamt_i[FIRST_LEVEL+j] ? shifted : x;
  end

  always_comb begin
    shamt_o = shamt_i;
    for (int j = 0; j < NUM_LEVELS; j++) shamt_o[FIRST_LEVEL+j] = 1'b0;
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter with valid/ready flow control, flush and sideband tag.
// Handshake: a transfer happens on any cycle where valid and ready are both high.
module pipe_shifter
  import pipe_shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int PER    = (LEVELS + STAGES - 1) / STAGES;

  logic              valid_q [STAGES];
  logic              valid_d [STAGES];
  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [WIDTH-1:0]  data_d  [STAGES];
  logic [LEVELS-1:0] shamt_q [STAGES];
  logic [LEVELS-1:0] shamt_d [STAGES];
  shift_mode_e       mode_q  [STAGES];
  shift_mode_e       mode_d  [STAGES];
  logic [TAG_W-1:0]  tag_q   [STAGES];
  logic [TAG_W-1:0]  tag_d   [STAGES];
  logic              sign_q  [STAGES];
  logic              sign_d  [STAGES];

  logic              adv       [STAGES];
  logic              src_valid [STAGES];
  logic [WIDTH-1:0]  src_data  [STAGES];
  logic [LEVELS-1:0] src_shamt [STAGES];
  shift_mode_e       src_mode  [STAGES];
  logic [TAG_W-1:0]  src_tag   [STAGES];
  logic              src_sign  [STAGES];
  logic [WIDTH-1:0]  sh_data   [STAGES];
  logic [LEVELS-1:0] sh_shamt  [STAGES];
  logic              unused_tail;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int FIRST = k * PER;
    localparam int NUM   = (FIRST >= LEVELS) ? 0 :
                           (((LEVELS - FIRST) < PER) ? (LEVELS - FIRST) : PER);

    if (k == 0) begin : g_src_in
      assign src_valid[k] = in_valid;
      assign src_data[k]  = in_data;
      assign src_shamt[k] = in_shamt;
      assign src_mode[k]  = shift_mode_e'(in_mode);
      assign src_tag[k]   = in_tag;
      assign src_sign[k]  = in_data[WIDTH-1];
    end else begin : g_src_prev
      assign src_valid[k] = valid_q[k-1];
      assign src_data[k]  = data_q[k-1];
      assign src_shamt[k] = shamt_q[k-1];
      assign src_mode[k]  = mode_q[k-1];
      assign src_tag[k]   = tag_q[k-1];
      assign src_sign[k]  = sign_q[k-1];
    end

    // A stage can load when it is empty or its contents move on this cycle.
    if (k == STAGES - 1) begin : g_adv_last
      assign adv[k] = !valid_q[k] || out_ready;
    end else begin : g_adv_mid
      assign adv[k] = !valid_q[k] || adv[k+1];
    end

    shift_level #(
      .WIDTH      (WIDTH),
      .FIRST_LEVEL(FIRST),
      .NUM_LEVELS (NUM)
    ) u_level (
      .data_i (src_data[k]),
      .shamt_i(src_shamt[k]),
      .mode_i (src_mode[k]),
      .sign_i (src_sign[k]),
      .data_o (sh_data[k]),
      .shamt_o(sh_shamt[k])
    );
  end

  // Payload registers only change on a real load, so outputs hold while stalled or empty.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
      shamt_d[k] = shamt_q[k];
      mode_d[k]  = mode_q[k];
      tag_d[k]   = tag_q[k];
      sign_d[k]  = sign_q[k];
      if (flush) begin
        valid_d[k] = 1'b0;
      end else if (adv[k]) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          data_d[k]  = sh_data[k];
          shamt_d[k] = sh_shamt[k];
          mode_d[k]  = src_mode[k];
          tag_d[k]   = src_tag[k];
          sign_d[k]  = src_sign[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= SH_SLL;
        tag_q[k]   <= '0;
        sign_q[k]  <= 1'b0;
      end else begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        mode_q[k]  <= mode_d[k];
        tag_q[k]   <= tag_d[k];
        sign_q[k]  <= sign_d[k];
      end
    end
  end

  assign in_ready    = adv[0];
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign out_tag     = tag_q[STAGES-1];
  assign unused_tail = ^{shamt_q[STAGES-1], mode_q[STAGES-1], sign_q[STAGES-1]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Randomised and directed bench for pipe_shifter (WIDTH=32, STAGES=2) with a queue scoreboard.
module tb_pipe_shifter;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int W     = WIDTH + TAG_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [4:0]       in_shamt;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           pop_cyc[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  int           n_pop  = 0;
  int           cyc    = 0;
  bit           hold   = 0;
  logic [W-1:0] hold_val;
  bit           rand_rdy = 0;
  bit           stall_done;
  int           base_pop;

  pipe_shifter #(.WIDTH(WIDTH), .STAGES(2), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the whole word.
  function automatic logic [WIDTH-1:0] model(logic [WIDTH-1:0] d, logic [4:0] s, logic [1:0] m);
    logic [2*WIDTH-1:0] dd;
    dd = {d, d} >> s;
    case (m)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return WIDTH'($signed(d) >>> s);
      default: return dd[WIDTH-1:0];
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: sampled on the falling edge, mirroring what the next rising edge commits.
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (rst || flush) begin
      exp_q.delete();
      hold = 0;
    end else begin
      if (hold) check("hold_stable", {out_valid, out_tag, out_data}, {1'b1, hold_val});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got %h with no result pending", {out_tag, out_data});
        end else begin
          e = exp_q.pop_front();
          check("result", {out_tag, out_data}, e);
        end
        got_q.push_back({out_tag, out_data});
        pop_cyc.push_back(cyc);
        n_pop++;
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_tag, model(in_data, in_shamt, in_mode)});
      hold     = out_valid && !out_ready;
      hold_val = {out_tag, out_data};
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(logic [WIDTH-1:0] d, logic [4:0] s, logic [1:0] m, logic [TAG_W-1:0] t);
    int n = 0;
    in_data  = d;
    in_shamt = s;
    in_mode  = m;
    in_tag   = t;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));

    // Latency: SLL 1 by 2.
    @(posedge clk); #1;
    send(32'h0000_0001, 5'd2, 2'b00, 5'd3);
    @(negedge clk);
    check("lat_cycle1_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("lat_cycle2_valid", 64'(out_valid), 64'(1));
    check("lat_cycle2_data", 64'(out_data), 64'h0000_0004);

    // Back-to-back SRA / SRL / ROTR.
    @(posedge clk); #1;
    got_q.delete(); pop_cyc.delete();
    send(32'h8000_0000, 5'd4, 2'b10, 5'd10);
    send(32'h8000_0000, 5'd4, 2'b01, 5'd11);
    send(32'h0000_0001, 5'd1, 2'b11, 5'd12);
    repeat (4) @(negedge clk);
    check("b2b_count", 64'(got_q.size()), 64'(3));
    if (got_q.size() == 3) begin
      check("b2b_sra", 64'(got_q[0]), {27'd0, 5'd10, 32'hF800_0000});
      check("b2b_srl", 64'(got_q[1]), {27'd0, 5'd11, 32'h0800_0000});
      check("b2b_rotr", 64'(got_q[2]), {27'd0, 5'd12, 32'h8000_0000});
      check("b2b_consec1", 64'(pop_cyc[1]), 64'(pop_cyc[0] + 1));
      check("b2b_consec2", 64'(pop_cyc[2]), 64'(pop_cyc[1] + 1));
    end

    // Back-pressure: 4 stalled cycles with 3 offers.
    @(posedge clk); #1;
    out_ready = 1'b0;
    got_q.delete();
    stall_done = 0;
    fork
      begin
        send(32'h1234_5678, 5'd8, 2'b00, 5'd20);
        send(32'h8765_4321, 5'd3, 2'b10, 5'd21);
        send(32'hDEAD_BEEF, 5'd16, 2'b11, 5'd22);
        stall_done = 1;
      end
    join_none
    repeat (4) @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'(0));
    check("stall_out_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && !stall_done; n++) @(negedge clk);
    check("stall_sender_done", 64'(stall_done), 64'(1));
    drain();
    check("stall_count", 64'(got_q.size()), 64'(3));
    if (got_q.size() == 3) check("stall_order", 64'({got_q[0][36:32], got_q[1][36:32], got_q[2][36:32]}),
                                  64'({5'd20, 5'd21, 5'd22}));

    // Flush with a simultaneous offer.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h0000_00F0, 5'd4, 2'b00, 5'd1);
    send(32'h0000_00F0, 5'd4, 2'b01, 5'd2);
    base_pop = n_pop;
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h5555_5555; in_shamt = 5'd1; in_tag = 5'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_no_result", 64'(n_pop), 64'(base_pop));
    @(posedge clk); #1;
    got_q.delete();
    send(32'hF000_000F, 5'd4, 2'b11, 5'd4);
    drain();
    check("flush_next_result", 64'(got_q.size() == 1 ? got_q[0] : '0), {27'd0, 5'd4, 32'hFF00_0000});

    // Reset with two operations in flight.
    @(posedge clk); #1;
    send(32'h0000_0003, 5'd1, 2'b00, 5'd5);
    send(32'h0000_0003, 5'd2, 2'b00, 5'd6);
    base_pop = n_pop;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_data", 64'(out_data), 64'(0));
    repeat (4) @(negedge clk);
    check("midrst_no_stale", 64'(n_pop), 64'(base_pop));

    // Zero shift in every mode.
    @(posedge clk); #1;
    got_q.delete();
    for (int m = 0; m < 4; m++) send(32'hA5A5_A5A5, 5'd0, 2'(m), 5'(m));
    drain();
    check("zero_count", 64'(got_q.size()), 64'(4));
    for (int m = 0; m < got_q.size(); m++) check("zero_data", 64'(got_q[m][31:0]), 64'hA5A5_A5A5);

    // Random traffic with random back-pressure and occasional flushes.
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 39) == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
      end
    end
    rand_rdy = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
